// File: rtl/sys_fence_ctrl.sv
`default_nettype none
// sys_fence_ctrl: sequences FENCE drain, EBREAK halt and ECALL events from the decoder.
// Optional SYSTEM-instruction counter is built only when SYS_EVENT_COUNT_EN is defined.
module sys_fence_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic        b_flag,
    input  logic        fence_flag,
    input  logic        is_ebreak,
    input  logic        sb_empty,
    input  logic        resume,
    output logic        pc_hold,
    output logic        flush,
    output logic        halted,
    output logic        ecall_pulse,
    output logic        fence_timeout,
    output logic [15:0] sys_count
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_WAITMEM = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [3:0] drain_q, drain_d;
    logic [7:0] wait_q, wait_d;
    logic       pc_hold_q, pc_hold_d;
    logic       flush_q, flush_d;
    logic       halted_q, halted_d;
    logic       ecall_q, ecall_d;
    logic       fto_q, fto_d;

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        wait_d  = wait_q;
        flush_d = 1'b0;
        ecall_d = 1'b0;
        fto_d   = fto_q;
        case (state_q)
            ST_RUN: begin
                if (instr_valid && b_flag) begin
                    if (is_ebreak) begin
                        state_d = ST_HALT;
                        flush_d = 1'b1;
                    end else begin
                        ecall_d = 1'b1;
                    end
                end else if (instr_valid && fence_flag) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_INIT;
                    flush_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q - 4'd1;
                if (drain_q == 4'd1) begin
                    state_d = ST_WAITMEM;
                    wait_d  = 8'd0;
                end
            end
            ST_WAITMEM: begin
                // A drained store path on the expiry cycle still counts as success.
                if (sb_empty) begin
                    state_d = ST_RUN;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_RUN;
                    fto_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        pc_hold_d = (state_d != ST_RUN);
        halted_d  = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            drain_q   <= 4'd0;
            wait_q    <= 8'd0;
            pc_hold_q <= 1'b0;
            flush_q   <= 1'b0;
            halted_q  <= 1'b0;
            ecall_q   <= 1'b0;
            fto_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            wait_q    <= wait_d;
            pc_hold_q <= pc_hold_d;
            flush_q   <= flush_d;
            halted_q  <= halted_d;
            ecall_q   <= ecall_d;
            fto_q     <= fto_d;
        end
    end

    assign pc_hold       = pc_hold_q;
    assign flush         = flush_q;
    assign halted        = halted_q;
    assign ecall_pulse   = ecall_q;
    assign fence_timeout = fto_q;

`ifdef SYS_EVENT_COUNT_EN
    logic [15:0] count_q;
    logic        sys_acc;

    assign sys_acc = (state_q == ST_RUN) && instr_valid && b_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 16'd0;
        end else if (sys_acc && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign sys_count = count_q;
`else
    assign sys_count = 16'h0000;
`endif

endmodule
`default_nettype wire
